// File: rtl/uart_receiver_if.sv
// uart_receiver_if
//   Delivery bundle between the UART receive engine and the register/FIFO
//   layer. Signal names match the receiver's historical output ports.
//
//   rx_data_o    received word, right-aligned, unused MSBs zero
//   rx_valid_o   one-cycle pulse qualifying data and both error flags
//   parity_err_o parity mismatch for the delivered word
//   frame_err_o  a stop bit was sampled low
//   rx_busy_o    receiver is inside a frame
//
//   master: the receiver (drives everything)
//   slave : the consumer (observes everything)
interface uart_receiver_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 rx_busy_o;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output parity_err_o,
        output frame_err_o,
        output rx_busy_o
    );

    modport slave (
        input rx_data_o,
        input rx_valid_o,
        input parity_err_o,
        input frame_err_o,
        input rx_busy_o
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial-to-parallel UART receive engine driven by a 16x oversampling tick.
//   Validates the start bit at its midpoint, samples every following bit one
//   bit-time later (its midpoint), and delivers one word per frame together
//   with parity and framing status.
//
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   ov_baud_rt_i  16x baud tick, one clk_i cycle wide
//   rx_i          asynchronous serial line, idle high
//   data_len_i    word length 00=5 .. 11=8, clamped to DATA_BITS
//   parity_en_i   a parity bit follows the data
//   parity_odd_i  1 = odd parity, 0 = even parity
//   stop_bits_i   0 = one stop bit, 1 = two stop bits
//   rx_if         delivery bundle (data, valid pulse, error flags, busy)
module uart_receiver #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ov_baud_rt_i,
    input  logic                   rx_i,
    input  logic [1:0]             data_len_i,
    input  logic                   parity_en_i,
    input  logic                   parity_odd_i,
    input  logic                   stop_bits_i,
    uart_receiver_if.master        rx_if
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [3:0]           tick_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_data;

    // Frame configuration, captured at start detection.
    logic [2:0]           cfg_last_idx;
    logic                 cfg_par_en;
    logic                 cfg_par_odd;
    logic                 cfg_two_stop;

    logic                 stop_second;
    logic                 par_err_acc;
    logic                 frm_err_acc;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 par_err_q;
    logic                 frm_err_q;

    logic [3:0]           req_len;
    logic [2:0]           last_idx_in;
    logic                 mid_start;
    logic                 mid_bit;

    // Requested word length clamped to the implemented width.
    always_comb begin
        req_len = {2'b00, data_len_i} + 4'd5;
        if (req_len > 4'(DATA_BITS)) begin
            req_len = 4'(DATA_BITS);
        end
        last_idx_in = 3'(req_len - 4'd1);
    end

    // Count 7 is eight ticks after start detection (mid start bit); count 15
    // is sixteen ticks after the previous sample (mid of every later bit).
    assign mid_start = ov_baud_rt_i && (tick_cnt == 4'd7);
    assign mid_bit   = ov_baud_rt_i && (tick_cnt == 4'd15);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            shift_data   <= '0;
            cfg_last_idx <= '0;
            cfg_par_en   <= 1'b0;
            cfg_par_odd  <= 1'b0;
            cfg_two_stop <= 1'b0;
            stop_second  <= 1'b0;
            par_err_acc  <= 1'b0;
            frm_err_acc  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            rx_meta    <= rx_i;
            rx_s       <= rx_meta;
            rx_valid_q <= 1'b0;

            if (ov_baud_rt_i) begin
                tick_cnt <= tick_cnt + 4'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (ov_baud_rt_i && !rx_s) begin
                        tick_cnt     <= '0;
                        state        <= ST_START;
                        cfg_last_idx <= last_idx_in;
                        cfg_par_en   <= parity_en_i;
                        cfg_par_odd  <= parity_odd_i;
                        cfg_two_stop <= stop_bits_i;
                        bit_idx      <= '0;
                        // Cleared so that unused MSBs read as zero.
                        shift_data   <= '0;
                        stop_second  <= 1'b0;
                        par_err_acc  <= 1'b0;
                        frm_err_acc  <= 1'b0;
                    end
                end

                ST_START: begin
                    if (mid_start) begin
                        if (!rx_s) begin
                            tick_cnt <= '0;
                            state    <= ST_DATA;
                        end else begin
                            // Line back high at mid start bit: glitch.
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_DATA: begin
                    if (mid_bit) begin
                        shift_data[bit_idx] <= rx_s;
                        if (bit_idx == cfg_last_idx) begin
                            bit_idx <= '0;
                            state   <= cfg_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (mid_bit) begin
                        // Total XOR is 0 for good even parity, 1 for good odd.
                        par_err_acc <= (^shift_data) ^ rx_s ^ cfg_par_odd;
                        state       <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (mid_bit) begin
                        if (cfg_two_stop && !stop_second) begin
                            stop_second <= 1'b1;
                            frm_err_acc <= frm_err_acc | ~rx_s;
                        end else begin
                            // Leaving at mid stop bit lets a back-to-back
                            // start edge be caught on the next tick.
                            state      <= ST_IDLE;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= shift_data;
                            par_err_q  <= par_err_acc;
                            frm_err_q  <= frm_err_acc | ~rx_s;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_if.rx_data_o    = rx_data_q;
    assign rx_if.rx_valid_o   = rx_valid_q;
    assign rx_if.parity_err_o = par_err_q;
    assign rx_if.frame_err_o  = frm_err_q;
    assign rx_if.rx_busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int unsigned DB       = 8;
    localparam int unsigned BIT_CLKS = 64;   // 16 ticks x 4 clocks per tick

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        rx = 1'b1;
    logic [1:0]  data_len = 2'b11;
    logic        pen = 1'b0;
    logic        podd = 1'b0;
    logic        two_stop = 1'b0;
    logic        busy_chk = 1'b0;

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;
    int unsigned tick_ph = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        mon_prev_v = 1'b0;

    uart_receiver_if #(.DATA_BITS(DB)) rif ();

    uart_receiver #(.DATA_BITS(DB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ov_baud_rt_i (tick),
        .rx_i         (rx),
        .data_len_i   (data_len),
        .parity_en_i  (pen),
        .parity_odd_i (podd),
        .stop_bits_i  (two_stop),
        .rx_if        (rif)
    );

    initial begin
        forever #5ns clk = ~clk;
    end

    // One tick every 4 clocks, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            tick = (tick_ph == 3);
            tick_ph = (tick_ph + 1) % 4;
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every rx_valid_o pops one expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1ns;
            if (mon_prev_v) check("valid_one_cycle", 32'(rif.rx_valid_o), 32'd0);
            if (rif.rx_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(rif.rx_valid_o), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_data", 32'(rif.rx_data_o), 32'(mon_e.data));
                    check("parity_err", 32'(rif.parity_err_o), 32'(mon_e.perr));
                    check("frame_err", 32'(rif.frame_err_o), 32'(mon_e.ferr));
                    check("busy_at_valid", 32'(rif.rx_busy_o), 32'd0);
                end
            end
            mon_prev_v = rif.rx_valid_o;
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
        if (busy_chk) check("busy_in_frame", 32'(rif.rx_busy_o), 32'd1);
        repeat (BIT_CLKS - 16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int unsigned nbits,
                              input logic p_en, input logic p_odd,
                              input logic p_force, input logic p_bit,
                              input logic two, input logic stop1, input logic stop2,
                              input logic mangle, input int unsigned gap);
        logic [7:0]  d;
        logic        pb;
        logic        ones_odd;
        exp_t        e;
        d        = data & 8'((32'd1 << nbits) - 32'd1);
        ones_odd = ($countones(d) % 2) == 1;
        pb       = p_force ? p_bit : (p_odd ? ~ones_odd : ones_odd);
        e.data   = d;
        // Even: error when data+parity holds an odd count of ones; odd: even count.
        e.perr   = p_en && (p_odd ? ~(ones_odd ^ pb) : (ones_odd ^ pb));
        e.ferr   = !stop1 || (two && !stop2);
        data_len = 2'(nbits - 5);
        pen      = p_en;
        podd     = p_odd;
        two_stop = two;
        exp_q.push_back(e);
        drive_bit(1'b0);
        if (mangle) begin
            data_len = ~data_len;
            pen      = ~pen;
            podd     = ~podd;
            two_stop = ~two_stop;
        end
        for (int unsigned i = 0; i < nbits; i++) drive_bit(d[i]);
        if (p_en) drive_bit(pb);
        drive_bit(stop1);
        if (two) drive_bit(stop2);
        rx       = 1'b1;
        data_len = 2'(nbits - 5);
        pen      = p_en;
        podd     = p_odd;
        two_stop = two;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_drain(input int unsigned bound);
        for (int unsigned i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(rif.rx_data_o),    32'd0);
        check({tag, "_valid"}, 32'(rif.rx_valid_o),   32'd0);
        check({tag, "_perr"},  32'(rif.parity_err_o), 32'd0);
        check({tag, "_ferr"},  32'(rif.frame_err_o),  32'd0);
        check({tag, "_busy"},  32'(rif.rx_busy_o),    32'd0);
    endtask

    initial begin
        logic [7:0] abort_word;

        // Reset state
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 0xA5 8N1, busy sampled in every bit, config scrambled mid-frame
        busy_chk = 1'b1;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 128);
        busy_chk = 1'b0;
        wait_drain(200);
        check("hold_data", 32'(rif.rx_data_o), 32'hA5);
        check("hold_valid", 32'(rif.rx_valid_o), 32'd0);

        // Parity: wrong even bit, then same bit under odd parity, then 7-bit even auto
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 128);
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 128);
        send_frame(8'h96, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 128);
        wait_drain(200);
        check("hold_perr", 32'(rif.parity_err_o), 32'd0);

        // Framing: stop low in 8N1, then second of two stops low, then clean 8N2
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 128);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 128);
        send_frame(8'hC3, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 128);
        wait_drain(200);

        // Start glitch: low for 5 ticks only
        rx = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_busy_early", 32'(rif.rx_busy_o), 32'd1);
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_before_mid", 32'(rif.rx_busy_o), 32'd1);
        repeat (56) @(negedge clk);
        check("glitch_busy_after", 32'(rif.rx_busy_o), 32'd0);
        repeat (64) @(negedge clk);

        // 5-bit back-to-back, no idle gap
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 128);
        wait_drain(200);
        check("hold_5bit", 32'(rif.rx_data_o), 32'h0A);

        // Reset in the middle of bit 4; nothing pushed, so any valid is flagged
        abort_word = 8'h6B;
        data_len = 2'b11;
        pen      = 1'b0;
        two_stop = 1'b0;
        drive_bit(1'b0);
        for (int unsigned i = 0; i < 4; i++) drive_bit(abort_word[i]);
        rx = abort_word[4];
        repeat (32) @(negedge clk);
        check("busy_before_abort", 32'(rif.rx_busy_o), 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_no_valid_busy", 32'(rif.rx_busy_o), 32'd0);

        // Clean frame after the abort
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 128);
        wait_drain(200);

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive engine, sitting directly downstream of the baud rate generator. It consumes the 16x-oversampling tick and the asynchronous serial line. It detects and validates the start bit, then samples each bit at its midpoint. It delivers one data word per frame with parity and framing status to the register/FIFO layer.

## Interface

Parameters:
- DATA_BITS, 8, maximum word width; legal range 5..8.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- ov_baud_rt_i  input  1  16x-baud tick from the baud rate generator; one clk_i cycle wide.
- rx_i  input  1  asynchronous serial line; idle high.
- data_len_i  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits. Values above DATA_BITS are clamped to DATA_BITS.
- parity_en_i  input  1  1 = a parity bit follows the data.
- parity_odd_i  input  1  1 = odd parity, 0 = even parity.
- stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits.
- rx_data_o  output  DATA_BITS  received word, LSB first on the line, right-aligned, unused MSBs 0.
- rx_valid_o  output  1  one-cycle pulse; rx_data_o, parity_err_o and frame_err_o are valid in this cycle.
- parity_err_o  output  1  parity mismatch for the delivered word.
- frame_err_o  output  1  any stop bit sampled low.
- rx_busy_o  output  1  high in every state other than IDLE.

## Operation

- rx_i passes through a 2-flop synchronizer to produce rx_s; it resets to 1. All decisions use rx_s.
- A 4-bit tick counter advances only on ov_baud_rt_i and wraps 15->0.
- A 3-bit bit index counts data bits.
- Configuration inputs are latched on the IDLE->START transition and held for the whole frame. Mid-frame changes have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rx_s==0, clear the tick counter and go to START.
  - START: at tick count 7 (mid start bit), sample rx_s. If 0, clear the tick counter and go to DATA. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: at tick count 15, shift rx_s into bit position [index] and increment the index. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: at tick count 15, sample the parity bit and go to STOP.
    - Even parity: error if XOR(data, parity bit) = 1.
    - Odd parity: error if XOR(data, parity bit) = 0.
  - STOP: at tick count 15, sample the stop bit; a 0 sets the frame error. With two stop bits, the second bit is sampled 16 ticks later. After the last stop sample, go to IDLE.
- Returning to IDLE at mid stop bit allows a back-to-back start bit to be detected on the next tick.
- Errors do not suppress delivery: the word is always presented with its flags.
- rx_data_o, parity_err_o and frame_err_o are registered. They hold their value until the next rx_valid_o.

## Timing

- Reset values: rx_data_o=0, rx_valid_o=0, parity_err_o=0, frame_err_o=0, rx_busy_o=0, FSM=IDLE, counters=0, synchronizer=1.
- Reset asserted mid-frame aborts the frame: no rx_valid_o, and all outputs return to their reset values on the next edge.
- Input latency: 2 clk_i cycles (synchronizer).
- Start qualification: 8 ticks after the tick that detected the low level.
- rx_valid_o rises on the clk_i edge after the cycle containing the last stop-bit sample tick, and lasts exactly 1 cycle.
- rx_busy_o falls in the same cycle that rx_valid_o rises.
- Ticks and rx_i changes between ticks are ignored except through rx_s at tick cycles. Ticks arriving on consecutive cycles are each counted.
- Frame length in ticks, from start detection to last stop sample: 8 + 16·(bits + parity + stop_count).

## Test plan

- Drive a tick every 4 clocks; send 0xA5, 8N1. Expect rx_data_o=0xA5 with a one-cycle rx_valid_o, both error flags 0, and rx_busy_o high throughout the frame.
- Send 0x3C with even parity enabled and a parity bit of 1 (wrong). Expect rx_data_o=0x3C and parity_err_o=1. Repeat with odd parity and the same bit of 1: expect parity_err_o=0.
- Send 0x55 with the stop bit forced low. Expect frame_err_o=1 and rx_data_o=0x55. With two stop bits, forcing only the second low still gives frame_err_o=1.
- Pulse rx_i low for 5 ticks only. Expect a return to IDLE, no rx_valid_o, and rx_busy_o to fall after count 7.
- 5-bit mode: send 0x1F then 0x0A back-to-back with no idle gap. Expect two rx_valid_o pulses, carrying 0x1F and 0x0A with MSBs zero.
- Assert rst_i in the middle of bit 4 of a frame. Expect all outputs at reset values and no rx_valid_o. A following clean 0x81 frame is received correctly.
